stream_mux_rr: RTL

Parametrised N-channel, WIDTH-bit stream multiplexer with a registered output and valid/ready handshakes on every port. It extends the lab's combinational 2:1 select into a sequential selector that picks among many sources per beat (round-robin or fixed priority), holds the chosen beat under backpressure, and reports which channel it came from. It sits between several producer blocks and one shared consumer.

---
 rtl/stream_mux_rr.sv | 78 +++++++
 1 files changed

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel registered stream mux, round-robin or fixed priority.
// Ports: clk, rst_n, in_valid/in_data/in_ready (N ch), out_valid/out_data/out_sel/out_ready.
module stream_mux_rr #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int MODE  = 0,
  parameter int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel,
  input  logic               out_ready
);

  localparam bit RR = (MODE == 0);

  logic [SELW-1:0] ptr;
  logic [SELW-1:0] start;
  logic [SELW-1:0] gnt_idx;
  logic [SELW-1:0] ptr_nxt;
  logic [N-1:0]    grant;
  logic            gnt_any;
  logic            load_en;
  logic            xfer;

  assign start   = RR ? ptr : '0;
  assign load_en = !out_valid || out_ready;

  // Scan start, start+1, ... modulo N; first valid wins.
  always_comb begin
    logic [SELW:0] idx;
    idx     = '0;
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, start} + (SELW+1)'(k);
      if (idx >= (SELW+1)'(N))
        idx = idx - (SELW+1)'(N);
      if (!gnt_any && in_valid[idx[SELW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = idx[SELW-1:0];
      end
    end
    if (gnt_any)
      grant[gnt_idx] = 1'b1;
  end

  // rst_n gates ready so nothing is handshaken while held in reset.
  assign in_ready = (load_en && rst_n) ? grant : '0;
  assign xfer     = load_en && gnt_any;

  assign ptr_nxt = (gnt_idx == SELW'(N-1)) ?
                   '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load_en) begin
      out_valid <= gnt_any;
      if (xfer) begin
        out_data <= in_data[gnt_idx*WIDTH +: WIDTH];
        out_sel  <= gnt_idx;
        if (RR)
          ptr <= ptr_nxt;
      end
    end
  end

endmodule
